// File: rtl/cv32e40p_rf_wb_arbiter_pkg.sv
// cv32e40p_rf_arb_pkg: shared types for the RF writeback arbiter.
// Queue entries are stored at the widest supported geometry (6-bit address,
// 32-bit data). Narrower instances zero-extend into these fields.
package cv32e40p_rf_arb_pkg;

  localparam int ARB_AW     = 6;
  localparam int ARB_DW     = 32;
  localparam int STAT_WIDTH = 16;

  typedef struct packed {
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] data;
    logic              valid;
  } wb_req_t;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_BLOCK  = 1'b1
  } arb_state_e;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cv32e40p_rf_wb_arbiter_if.sv
// Writeback bus between the EX/LSU/APU sources, the ID hazard check and the
// register file write ports. The arbiter uses the slave modport.
interface cv32e40p_rf_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);

  logic                  ex_we_i;
  logic [ADDR_WIDTH-1:0] ex_waddr_i;
  logic [DATA_WIDTH-1:0] ex_wdata_i;

  logic                  lsu_we_i;
  logic [ADDR_WIDTH-1:0] lsu_waddr_i;
  logic [DATA_WIDTH-1:0] lsu_wdata_i;

  logic                  apu_valid_i;
  logic                  apu_ready_o;
  logic [ADDR_WIDTH-1:0] apu_waddr_i;
  logic [DATA_WIDTH-1:0] apu_wdata_i;

  logic [ADDR_WIDTH-1:0] raddr_a_i;
  logic [ADDR_WIDTH-1:0] raddr_b_i;
  logic [ADDR_WIDTH-1:0] raddr_c_i;
  logic                  hazard_o;

  logic                  rf_we_a_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_a_o;
  logic [DATA_WIDTH-1:0] rf_wdata_a_o;
  logic                  rf_we_b_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_b_o;
  logic [DATA_WIDTH-1:0] rf_wdata_b_o;

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  apu_valid_i, apu_waddr_i, apu_wdata_i,
    output apu_ready_o,
    input  raddr_a_i, raddr_b_i, raddr_c_i,
    output hazard_o,
    output rf_we_a_o, rf_waddr_a_o, rf_wdata_a_o,
    output rf_we_b_o, rf_waddr_b_o, rf_wdata_b_o
  );

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output apu_valid_i, apu_waddr_i, apu_wdata_i,
    input  apu_ready_o,
    output raddr_a_i, raddr_b_i, raddr_c_i,
    input  hazard_o,
    input  rf_we_a_o, rf_waddr_a_o, rf_wdata_a_o,
    input  rf_we_b_o, rf_waddr_b_o, rf_wdata_b_o
  );

endinterface

// File: rtl/cv32e40p_rf_wb_fifo.sv
// Deferral queue for APU results that lost the W2 port.
// Circular buffer of wb_req_t. Entries whose address matches a same-cycle
// EX/LSU write are invalidated in place. They stay in order and are dropped
// without a write when they reach the head.
module cv32e40p_rf_wb_fifo
  import cv32e40p_rf_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk_int,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  wb_req_t                      push_req_i,
  input  logic                         pop_i,
  input  logic                         kill_a_en_i,
  input  logic [ARB_AW-1:0]            kill_a_addr_i,
  input  logic                         kill_b_en_i,
  input  logic [ARB_AW-1:0]            kill_b_addr_i,
  output logic [ARB_AW-1:0]            head_addr_o,
  output logic [ARB_DW-1:0]            head_data_o,
  output logic                         head_live_o,
  output logic                         empty_o,
  output logic [CNT_W-1:0]             count_o,
  output logic [CNT_W-1:0]             count_nxt_o,
  output logic [DEPTH-1:0]             ent_valid_o,
  output logic [DEPTH-1:0][ARB_AW-1:0] ent_addr_o
);

  wb_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] kill;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flag live entries overwritten by a younger EX/LSU write this cycle.
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = mem_q[i].valid &
                ((kill_a_en_i & (mem_q[i].addr == kill_a_addr_i)) |
                 (kill_b_en_i & (mem_q[i].addr == kill_b_addr_i)));
    end
  end

  // Head view, occupancy and per-entry export for the hazard compare.
  always_comb begin
    empty_o     = (count_q == '0);
    head_addr_o = mem_q[rd_ptr_q].addr;
    head_data_o = mem_q[rd_ptr_q].data;
    head_live_o = ~empty_o & mem_q[rd_ptr_q].valid & ~kill[rd_ptr_q];
    count_o     = count_q;
    count_nxt_o = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_o[i] = mem_q[i].valid;
      ent_addr_o[i]  = mem_q[i].addr;
    end
  end

  // Storage update: kill, then pop, then push (push wins on a shared slot when full).
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) mem_q[i].valid <= 1'b0;
      end
      if (pop_i) begin
        mem_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q              <= ptr_inc(rd_ptr_q);
      end
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_req_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      count_q <= count_nxt_o;
    end
  end

endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// cv32e40p_rf_wb_arbiter: shares RF write ports W1/W2 among EX, LSU and APU.
// W1 carries EX unchanged. W2 carries LSU, else the queue head, else a direct APU result.
// APU results that cannot write directly are queued in order. hazard_o flags reads of
// registers whose APU result is still pending.
// Optional feature: define CV32E40P_RF_ARB_STATS_EN to build saturating deferral and
// backpressure counters. Without it, stat_*_o are tied to zero.
//
// state      | meaning
// ARB_NORMAL | queue has a free slot, APU is always accepted
// ARB_BLOCK  | queue full, APU accepted only when the head drains this cycle
module cv32e40p_rf_wb_arbiter
  import cv32e40p_rf_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                    clk_int,
  input  logic                    rst_n,
  cv32e40p_rf_wb_arbiter_if.slave bus,
  output logic                    q_full_o,
  output logic [STAT_WIDTH-1:0]   stat_defer_o,
  output logic [STAT_WIDTH-1:0]   stat_bp_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  arb_state_e               state_q, state_d;
  logic                     ex_live, lsu_live, apu_ready, apu_acc, apu_live, apu_direct;
  logic                     push, pop;
  wb_req_t                  apu_req;
  logic [ARB_AW-1:0]        ex_addr, lsu_addr, apu_addr, ra, rb, rc;
  logic [ARB_AW-1:0]        head_addr;
  logic [ARB_DW-1:0]        head_data;
  logic                     head_live, fifo_empty;
  logic [CNT_W-1:0]         occ, occ_nxt;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][ARB_AW-1:0] ent_addr;

  // Widen addresses to queue geometry so every compare is done at one width.
  always_comb begin
    ex_addr  = ARB_AW'(bus.ex_waddr_i);
    lsu_addr = ARB_AW'(bus.lsu_waddr_i);
    apu_addr = ARB_AW'(bus.apu_waddr_i);
    ra       = ARB_AW'(bus.raddr_a_i);
    rb       = ARB_AW'(bus.raddr_b_i);
    rc       = ARB_AW'(bus.raddr_c_i);
  end

  // Source qualification: drop x0 writes, EX (younger) overrides LSU on the same register.
  always_comb begin
    ex_live    = bus.ex_we_i & (ex_addr != '0);
    lsu_live   = bus.lsu_we_i & (lsu_addr != '0) & ~(ex_live & (lsu_addr == ex_addr));
    apu_ready  = (state_q == ARB_NORMAL) | ~lsu_live;
    apu_acc    = bus.apu_valid_i & apu_ready;
    apu_live   = apu_acc & (apu_addr != '0);
    apu_direct = apu_live & fifo_empty & ~lsu_live;
    push       = apu_live & ~apu_direct;
    pop        = ~fifo_empty & (~head_live | ~lsu_live);
    apu_req    = '{addr: apu_addr, data: ARB_DW'(bus.apu_wdata_i), valid: 1'b1};
  end

  cv32e40p_rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_int       (clk_int),
    .rst_n         (rst_n),
    .push_i        (push),
    .push_req_i    (apu_req),
    .pop_i         (pop),
    .kill_a_en_i   (ex_live),
    .kill_a_addr_i (ex_addr),
    .kill_b_en_i   (lsu_live),
    .kill_b_addr_i (lsu_addr),
    .head_addr_o   (head_addr),
    .head_data_o   (head_data),
    .head_live_o   (head_live),
    .empty_o       (fifo_empty),
    .count_o       (occ),
    .count_nxt_o   (occ_nxt),
    .ent_valid_o   (ent_valid),
    .ent_addr_o    (ent_addr)
  );

  // W1 pass-through of EX and W2 priority mux LSU > queue head > direct APU.
  always_comb begin
    bus.rf_we_a_o    = ex_live;
    bus.rf_waddr_a_o = bus.ex_waddr_i;
    bus.rf_wdata_a_o = bus.ex_wdata_i;
    bus.rf_we_b_o    = 1'b0;
    bus.rf_waddr_b_o = '0;
    bus.rf_wdata_b_o = '0;
    if (lsu_live) begin
      bus.rf_we_b_o    = 1'b1;
      bus.rf_waddr_b_o = bus.lsu_waddr_i;
      bus.rf_wdata_b_o = bus.lsu_wdata_i;
    end else if (head_live) begin
      bus.rf_we_b_o    = 1'b1;
      bus.rf_waddr_b_o = head_addr[ADDR_WIDTH-1:0];
      bus.rf_wdata_b_o = head_data[DATA_WIDTH-1:0];
    end else if (apu_direct) begin
      bus.rf_we_b_o    = 1'b1;
      bus.rf_waddr_b_o = bus.apu_waddr_i;
      bus.rf_wdata_b_o = bus.apu_wdata_i;
    end
  end

  // Read hazard against live queued destinations and this cycle's deferred APU result.
  always_comb begin
    bus.hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ((ent_addr[i] == ra) || (ent_addr[i] == rb) || (ent_addr[i] == rc)))
        bus.hazard_o = 1'b1;
    end
    if (push && ((apu_addr == ra) || (apu_addr == rb) || (apu_addr == rc)))
      bus.hazard_o = 1'b1;
  end

  // Acceptance and queue-full status for the APU side.
  always_comb begin
    bus.apu_ready_o = apu_ready;
    q_full_o        = (occ == CNT_W'(DEPTH));
  end

  // FSM state register.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_NORMAL;
    else        state_q <= state_d;
  end

  // FSM next state from post-update queue occupancy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_NORMAL: if (occ_nxt == CNT_W'(DEPTH)) state_d = ARB_BLOCK;
      ARB_BLOCK:  if (occ_nxt <  CNT_W'(DEPTH)) state_d = ARB_NORMAL;
      default:    state_d = ARB_NORMAL;
    endcase
  end

`ifdef CV32E40P_RF_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] defer_q, bp_q;

  // Saturating counts of deferred APU results and APU backpressure cycles.
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      defer_q <= '0;
      bp_q    <= '0;
    end else begin
      if (push) defer_q <= sat_inc(defer_q);
      if (bus.apu_valid_i & ~apu_ready) bp_q <= sat_inc(bp_q);
    end
  end

  assign stat_defer_o = defer_q;
  assign stat_bp_o    = bp_q;
`else
  assign stat_defer_o = '0;
  assign stat_bp_o    = '0;
`endif

endmodule
